// File: rtl/title_pkg.sv
// Shared types and constants for the title-screen logo path.
package title_pkg;

  localparam int COORD_W  = 11;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SLIDE = 2'd1,
    HOLD  = 2'd2,
    BLINK = 2'd3
  } title_state_t;

endpackage

// File: rtl/rect_offset_gen.sv
// Registered rectangle hit test and offset generator.
// One clk of latency from pixelX/pixelY to InsideRectangle/offsetX/offsetY.
// Reusable for any fixed-size box (logo, ball, player, score).
module rect_offset_gen
  import title_pkg::*;
#(
  parameter int OBJECT_WIDTH_X  = 60,
  parameter int OBJECT_HEIGHT_Y = 20
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic [COORD_W-1:0] pixelX,
  input  logic [COORD_W-1:0] pixelY,
  input  logic [COORD_W-1:0] topLeftX,
  input  logic [COORD_W-1:0] topLeftY,
  input  logic               visible,
  output logic [COORD_W-1:0] offsetX,
  output logic [COORD_W-1:0] offsetY,
  output logic               InsideRectangle
);

  // Bounds are widened by one bit so right/bottom edges near the top of
  // the coordinate range cannot wrap.
  logic [COORD_W:0]   px_p0, py_p0, x_lo_p0, x_hi_p0, y_lo_p0, y_hi_p0;
  logic               inside_p0;
  logic [COORD_W-1:0] offx_p0, offy_p0;

  logic               inside_p1;
  logic [COORD_W-1:0] offx_p1, offy_p1;

  // Stage p0: combinational hit test against the current top-left corner.
  always_comb begin
    px_p0     = {1'b0, pixelX};
    py_p0     = {1'b0, pixelY};
    x_lo_p0   = {1'b0, topLeftX};
    y_lo_p0   = {1'b0, topLeftY};
    x_hi_p0   = x_lo_p0 + (COORD_W+1)'(OBJECT_WIDTH_X);
    y_hi_p0   = y_lo_p0 + (COORD_W+1)'(OBJECT_HEIGHT_Y);
    inside_p0 = visible &&
                (px_p0 >= x_lo_p0) && (px_p0 < x_hi_p0) &&
                (py_p0 >= y_lo_p0) && (py_p0 < y_hi_p0);
    offx_p0   = '0;
    offy_p0   = '0;
    if (inside_p0) begin
      offx_p0 = pixelX - topLeftX;
      offy_p0 = pixelY - topLeftY;
    end
  end

  // Stage p1: register the hit and offsets; cleared so a reset frame draws nothing.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      inside_p1 <= 1'b0;
      offx_p1   <= '0;
      offy_p1   <= '0;
    end else begin
      inside_p1 <= inside_p0;
      offx_p1   <= offx_p0;
      offy_p1   <= offy_p0;
    end
  end

  assign InsideRectangle = inside_p1;
  assign offsetX         = offx_p1;
  assign offsetY         = offy_p1;

endmodule

// File: rtl/title_rect_animator.sv
// Title logo animator: slides the logo from START_Y down to REST_Y, holds it
// for HOLD_FRAMES, then (when TITLE_BLINK_EN is defined) blinks it with a
// BLINK_HALF-frame half-period. Without TITLE_BLINK_EN the logo stays in
// HOLD and visible indefinitely. All animation steps on startOfFrame;
// enable=0 drops back to IDLE on the next edge.
module title_rect_animator
  import title_pkg::*;
#(
  parameter int OBJECT_WIDTH_X  = 60,
  parameter int OBJECT_HEIGHT_Y = 20,
  parameter int REST_X          = 290,
  parameter int START_Y         = 0,
  parameter int REST_Y          = 200,
  parameter int SPEED           = 2,
  parameter int HOLD_FRAMES     = 60,
  parameter int BLINK_HALF      = 15
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               enable,
  input  logic               skip,
  input  logic [COORD_W-1:0] pixelX,
  input  logic [COORD_W-1:0] pixelY,
  output logic [COORD_W-1:0] offsetX,
  output logic [COORD_W-1:0] offsetY,
  output logic               InsideRectangle,
  output logic               animDone,
  output logic [COORD_W-1:0] topLeftY
);

  // One counter serves both the hold and blink periods.
  localparam int CNT_MAX = (HOLD_FRAMES > BLINK_HALF) ? HOLD_FRAMES : BLINK_HALF;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [COORD_W-1:0] START_Y_C = COORD_W'(START_Y);
  localparam logic [COORD_W-1:0] REST_Y_C  = COORD_W'(REST_Y);
  localparam logic [COORD_W-1:0] REST_X_C  = COORD_W'(REST_X);
  localparam logic [COORD_W:0]   REST_Y_W  = (COORD_W+1)'(REST_Y);
  localparam logic [COORD_W:0]   SPEED_W   = (COORD_W+1)'(SPEED);

  title_state_t       state, state_nxt;
  logic [COORD_W-1:0] y_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               visible, visible_nxt;
  logic [COORD_W:0]   y_sum;

  // Clamp a widened slide position to the rest row so the logo never overshoots.
  function automatic logic [COORD_W-1:0] sat_rest(input logic [COORD_W:0] sum);
    if (sum >= REST_Y_W) sat_rest = REST_Y_C;
    else                 sat_rest = sum[COORD_W-1:0];
  endfunction

  // Animation state, position, frame counter and visibility registers.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state    <= IDLE;
      topLeftY <= START_Y_C;
      cnt      <= '0;
      visible  <= 1'b0;
    end else begin
      state    <= state_nxt;
      topLeftY <= y_nxt;
      cnt      <= cnt_nxt;
      visible  <= visible_nxt;
    end
  end

  // Next-state logic: enable=0 wins over everything, skip wins over a slide step.
  always_comb begin
    state_nxt   = state;
    y_nxt       = topLeftY;
    cnt_nxt     = cnt;
    visible_nxt = visible;
    y_sum       = {1'b0, topLeftY} + SPEED_W;
    if (!enable) begin
      state_nxt   = IDLE;
      cnt_nxt     = '0;
      visible_nxt = 1'b0;
    end else if (startOfFrame) begin
      unique case (state)
        IDLE: begin
          state_nxt   = SLIDE;
          y_nxt       = START_Y_C;
          cnt_nxt     = '0;
          visible_nxt = 1'b1;
        end
        SLIDE: begin
          visible_nxt = 1'b1;
          if (skip || (y_sum >= REST_Y_W)) begin
            state_nxt = HOLD;
            y_nxt     = REST_Y_C;
            cnt_nxt   = '0;
          end else begin
            y_nxt = sat_rest(y_sum);
          end
        end
        HOLD: begin
          visible_nxt = 1'b1;
          if (cnt == CNT_W'(HOLD_FRAMES - 1)) begin
`ifdef TITLE_BLINK_EN
            state_nxt = BLINK;
            cnt_nxt   = '0;
`else
            cnt_nxt   = cnt;
`endif
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        BLINK: begin
`ifdef TITLE_BLINK_EN
          if (cnt == CNT_W'(BLINK_HALF - 1)) begin
            cnt_nxt     = '0;
            visible_nxt = ~visible;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
`else
          state_nxt   = HOLD;
          visible_nxt = 1'b1;
`endif
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign animDone = (state == HOLD) || (state == BLINK);

  rect_offset_gen #(
    .OBJECT_WIDTH_X (OBJECT_WIDTH_X),
    .OBJECT_HEIGHT_Y(OBJECT_HEIGHT_Y)
  ) u_rect (
    .clk            (clk),
    .resetN         (resetN),
    .pixelX         (pixelX),
    .pixelY         (pixelY),
    .topLeftX       (REST_X_C),
    .topLeftY       (topLeftY),
    .visible        (visible),
    .offsetX        (offsetX),
    .offsetY        (offsetY),
    .InsideRectangle(InsideRectangle)
  );

endmodule
